sram_arbiter: RTL

- Shares the board's single asynchronous SRAM between two requesters: the CPU memory port (via the memory control unit) and a program-loader/debug port.
- Sequences every access into setup, strobe and hold phases with a parameterised wait count, drives all SRAM pins and owns the SRAM_DQ tri-state.
- Round-robin arbitration on simultaneous requests; a one-cycle Ack completes each transaction.

---
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single asynchronous SRAM: round-robin grant, setup/strobe/hold sequencing.
// Optional per-byte write enables when ELC3_SRAM_BYTE_EN is defined.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              Cpu_Req,
    input  logic              Cpu_We,
    input  logic [ADDR_W-1:0] Cpu_Addr,
    input  logic [15:0]       Cpu_Wdata,
`ifdef ELC3_SRAM_BYTE_EN
    input  logic [1:0]        Cpu_Be,
`endif
    output logic [15:0]       Cpu_Rdata,
    output logic              Cpu_Ack,
    input  logic              Ld_Req,
    input  logic              Ld_We,
    input  logic [ADDR_W-1:0] Ld_Addr,
    input  logic [15:0]       Ld_Wdata,
`ifdef ELC3_SRAM_BYTE_EN
    input  logic [1:0]        Ld_Be,
`endif
    output logic [15:0]       Ld_Rdata,
    output logic              Ld_Ack,
    output logic              Busy,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_check
            $error("sram_arbiter: WAIT_CYCLES must be in the range 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_LDR = 1'b1;
    localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);

    state_t              state_reg, state_next;
    logic                owner_reg, owner_next;
    logic                last_grant_reg, last_grant_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [15:0]         wdata_reg, wdata_next;
    logic [3:0]          cnt_reg, cnt_next;
`ifdef ELC3_SRAM_BYTE_EN
    logic [1:0]          be_reg, be_next;
`endif
    logic [15:0]         rdata_reg [2];

    logic                grant_ldr;
    logic                capture;
    logic                dq_oe;

    // On a tie the port that was not served last wins.
    assign grant_ldr = Ld_Req && (!Cpu_Req || (last_grant_reg == OWNER_CPU));

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
`ifdef ELC3_SRAM_BYTE_EN
        be_next         = be_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (Cpu_Req || Ld_Req) begin
                    owner_next      = grant_ldr ? OWNER_LDR : OWNER_CPU;
                    last_grant_next = grant_ldr ? OWNER_LDR : OWNER_CPU;
                    we_next         = grant_ldr ? Ld_We : Cpu_We;
                    addr_next       = grant_ldr ? Ld_Addr : Cpu_Addr;
                    wdata_next      = grant_ldr ? Ld_Wdata : Cpu_Wdata;
`ifdef ELC3_SRAM_BYTE_EN
                    be_next         = grant_ldr ? Ld_Be : Cpu_Be;
`endif
                    state_next      = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = CNT_LOAD;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_CPU;
            last_grant_reg <= OWNER_LDR;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= 4'd0;
`ifdef ELC3_SRAM_BYTE_EN
            be_reg         <= 2'b00;
`endif
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
`ifdef ELC3_SRAM_BYTE_EN
            be_reg         <= be_next;
`endif
        end
    end

    // Read data is sampled on the edge that ends the last strobe cycle.
    assign capture = (state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge Clk) begin
                if (!Reset_N) begin
                    rdata_reg[gi] <= 16'h0000;
                end else if (capture && (owner_reg == 1'(gi))) begin
                    rdata_reg[gi] <= SRAM_DQ;
                end
            end
        end
    endgenerate

    assign Cpu_Rdata = rdata_reg[0];
    assign Ld_Rdata  = rdata_reg[1];
    assign Cpu_Ack   = (state_reg == DONE) && (owner_reg == OWNER_CPU);
    assign Ld_Ack    = (state_reg == DONE) && (owner_reg == OWNER_LDR);
    assign Busy      = (state_reg != IDLE);

    assign SRAM_CE_N = (state_reg == IDLE);
    assign SRAM_OE_N = !(!we_reg && ((state_reg == SETUP) || (state_reg == ACCESS)));
    assign SRAM_WE_N = !(we_reg && (state_reg == ACCESS));
    assign SRAM_ADDR = addr_reg;

    // Write data stays on the bus through DONE to cover the SRAM data hold time.
    assign dq_oe   = we_reg && ((state_reg == ACCESS) || (state_reg == DONE));
    assign SRAM_DQ = dq_oe ? wdata_reg : 16'hzzzz;

`ifdef ELC3_SRAM_BYTE_EN
    assign SRAM_LB_N = (state_reg == IDLE) ? 1'b1 : (we_reg ? ~be_reg[0] : 1'b0);
    assign SRAM_UB_N = (state_reg == IDLE) ? 1'b1 : (we_reg ? ~be_reg[1] : 1'b0);
`else
    assign SRAM_LB_N = SRAM_CE_N;
    assign SRAM_UB_N = SRAM_CE_N;
`endif

endmodule
